// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and
// standard bit-timing constants for the 12 MHz domain.
`timescale 1ns/1ps
package uart_pkg;

  localparam int unsigned UART_CLKS_9600_12M = 1250;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } uart_rx_state_t;

  function automatic logic [15:0] bit_last(
    input int unsigned cpb
  );
    return 16'(cpb - 1);
  endfunction

  function automatic logic [15:0] half_last(
    input int unsigned cpb
  );
    return 16'((cpb / 2) - 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for one async input.
// Ports: clk, rst_n (async low), d (async in), q (synced out).
`timescale 1ns/1ps
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver with valid/ready byte output.
// Ports: clk, rst_n, rx | rx_data, rx_valid, rx_ready, rx_busy, frame_err, overrun.
`timescale 1ns/1ps
module uart_rx_8n1
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_9600_12M
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam logic [15:0] BIT_LAST  = bit_last(CLKS_PER_BIT);
  localparam logic [15:0] HALF_LAST = half_last(CLKS_PER_BIT);

  logic           rx_s;
  logic           rx_q;
  uart_rx_state_t state;
  logic [15:0]    cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shift;
  logic           tick;
  logic           accept;

  // Synchroniser resets low so a line held low at reset
  // release never looks like a falling edge.
  sync_2ff #(
    .RST_VAL(1'b0)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rx),
    .q    (rx_s)
  );

  assign tick   = (cnt == 16'd0);
  assign accept = rx_valid && rx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rx_q      <= 1'b0;
      cnt       <= 16'd0;
      bit_idx   <= 3'd0;
      shift     <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      rx_busy   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_q      <= rx_s;
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      // A load later in this block overrides the clear.
      if (accept) begin
        rx_valid <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (rx_q && !rx_s) begin
            state   <= START;
            cnt     <= HALF_LAST;
            rx_busy <= 1'b1;
          end
        end

        START: begin
          if (!tick) begin
            cnt <= cnt - 16'd1;
          end else if (!rx_s) begin
            state   <= DATA;
            cnt     <= BIT_LAST;
            bit_idx <= 3'd0;
          end else begin
            state   <= IDLE;
            cnt     <= BIT_LAST;
            rx_busy <= 1'b0;
          end
        end

        DATA: begin
          if (!tick) begin
            cnt <= cnt - 16'd1;
          end else begin
            shift <= {rx_s, shift[7:1]};
            cnt   <= BIT_LAST;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end

        STOP: begin
          if (!tick) begin
            cnt <= cnt - 16'd1;
          end else if (rx_s) begin
            rx_data  <= shift;
            rx_valid <= 1'b1;
            overrun  <= rx_valid && !rx_ready;
            state    <= IDLE;
            cnt      <= BIT_LAST;
            rx_busy  <= 1'b0;
          end else begin
            frame_err <= 1'b1;
            state     <= WAIT_IDLE;
            cnt       <= BIT_LAST;
          end
        end

        // Hold off until the line is released so a break
        // cannot retrigger reception.
        WAIT_IDLE: begin
          if (rx_s) begin
            state   <= IDLE;
            cnt     <= BIT_LAST;
            rx_busy <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Bench for uart_rx_8n1: 1250-clk/bit instance for exact
// timing, 8-clk/bit instance for table and corner cases.
`timescale 1ns/1ps
module tb_uart_rx_8n1;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic       rx_a, rx_b;
  logic       rdy_a, rdy_b;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b;
  logic       busy_a, busy_b;
  logic       fe_a, fe_b;
  logic       ov_a, ov_b;

  int n_chk = 0;
  int n_fail = 0;

  int a_v = 0, a_fe = 0, a_ov = 0, a_bz = 0;
  int b_v = 0, b_fe = 0, b_ov = 0, b_bz = 0;

  always #5 clk = ~clk;

  uart_rx_8n1 #(.CLKS_PER_BIT(1250)) dut_a (
    .clk      (clk),
    .rst_n    (rst_a),
    .rx       (rx_a),
    .rx_data  (data_a),
    .rx_valid (valid_a),
    .rx_ready (rdy_a),
    .rx_busy  (busy_a),
    .frame_err(fe_a),
    .overrun  (ov_a)
  );

  uart_rx_8n1 #(.CLKS_PER_BIT(8)) dut_b (
    .clk      (clk),
    .rst_n    (rst_b),
    .rx       (rx_b),
    .rx_data  (data_b),
    .rx_valid (valid_b),
    .rx_ready (rdy_b),
    .rx_busy  (busy_b),
    .frame_err(fe_b),
    .overrun  (ov_b)
  );

  always @(negedge clk) begin
    if (valid_a) a_v  <= a_v + 1;
    if (fe_a)    a_fe <= a_fe + 1;
    if (ov_a)    a_ov <= a_ov + 1;
    if (busy_a)  a_bz <= a_bz + 1;
    if (valid_b) b_v  <= b_v + 1;
    if (fe_b)    b_fe <= b_fe + 1;
    if (ov_b)    b_ov <= b_ov + 1;
    if (busy_b)  b_bz <= b_bz + 1;
  end

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) rx_b = v;
    else     rx_a = v;
  endtask

  task automatic send(input bit sel, input logic [7:0] d,
                      input bit stop, input real bns,
                      input int gap);
    drive(sel, 1'b0);
    #(bns);
    for (int i = 0; i < 8; i++) begin
      drive(sel, d[i]);
      #(bns);
    end
    drive(sel, stop);
    #(bns);
    if (gap > 0) begin
      drive(sel, 1'b1);
      #(bns * gap);
    end
  endtask

  typedef struct {
    logic [7:0] d;
    bit         stop;
    real        bns;
    int         gap;
    bit         rdy;
    logic [7:0] e_data;
    bit         e_valid;
    int         e_fe;
    int         e_ov;
  } vec_t;

  vec_t tbl[9];

  int s_v, s_fe, s_ov, s_bz;
  int first_k, fall_k;

  initial begin
    tbl[0] = '{8'hFF, 1'b1, 80.0, 2, 1'b1, 8'hFF, 1'b0, 0, 0};
    tbl[1] = '{8'h00, 1'b1, 78.4, 2, 1'b1, 8'h00, 1'b0, 0, 0};
    tbl[2] = '{8'hFF, 1'b1, 78.4, 2, 1'b1, 8'hFF, 1'b0, 0, 0};
    tbl[3] = '{8'h00, 1'b1, 81.6, 2, 1'b1, 8'h00, 1'b0, 0, 0};
    tbl[4] = '{8'hFF, 1'b1, 81.6, 2, 1'b1, 8'hFF, 1'b0, 0, 0};
    tbl[5] = '{8'h55, 1'b0, 80.0, 2, 1'b1, 8'hFF, 1'b0, 1, 0};
    tbl[6] = '{8'hA5, 1'b1, 80.0, 0, 1'b0, 8'hA5, 1'b1, 0, 0};
    tbl[7] = '{8'h3C, 1'b1, 80.0, 0, 1'b0, 8'h3C, 1'b1, 0, 1};
    tbl[8] = '{8'h81, 1'b1, 80.0, 2, 1'b1, 8'h81, 1'b0, 0, 0};

    rst_a = 1'b0; rst_b = 1'b0;
    rx_a = 1'b1;  rx_b = 1'b1;
    rdy_a = 1'b1; rdy_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst a data",  data_a,  0);
    check("rst a valid", valid_a, 0);
    check("rst a busy",  busy_a,  0);
    check("rst a ferr",  fe_a,    0);
    check("rst a ovr",   ov_a,    0);
    check("rst b data",  data_b,  0);
    check("rst b valid", valid_b, 0);
    check("rst b busy",  busy_b,  0);
    check("rst b ferr",  fe_b,    0);
    check("rst b ovr",   ov_b,    0);
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (20) @(posedge clk);

    // 0x46 at 1250 clk/bit: exact valid timing and width.
    @(posedge clk); #1;
    s_v = a_v; s_fe = a_fe; s_ov = a_ov;
    first_k = -1;
    fork
      send(1'b0, 8'h46, 1'b1, 12500.0, 1);
    join_none
    for (int k = 1; k <= 11900; k++) begin
      @(posedge clk); #1;
      if (valid_a && first_k < 0) first_k = k;
    end
    wait fork;
    check("F valid edge", first_k, 625 + 9 * 1250 + 3);
    check("F valid width", a_v - s_v, 1);
    check("F data", data_a, 8'h46);
    check("F ferr", a_fe - s_fe, 0);
    check("F ovr", a_ov - s_ov, 0);

    // 400-cycle low glitch on idle line.
    @(posedge clk); #1;
    s_v = a_v; s_bz = a_bz; s_fe = a_fe;
    fall_k = -1;
    fork
      begin
        rx_a = 1'b0;
        #4000;
        rx_a = 1'b1;
      end
    join_none
    for (int k = 1; k <= 1000; k++) begin
      @(posedge clk); #1;
      if (!busy_a && fall_k < 0 && a_bz != s_bz) fall_k = k;
    end
    wait fork;
    check("glitch busy cycles", a_bz - s_bz, 625);
    check("glitch busy fall", fall_k, 628);
    check("glitch valid", a_v - s_v, 0);
    check("glitch ferr", a_fe - s_fe, 0);
    check("glitch busy end", busy_a, 0);

    // Table of frames on the 8 clk/bit instance.
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      rdy_b = tbl[i].rdy;
      s_fe = b_fe; s_ov = b_ov;
      send(1'b1, tbl[i].d, tbl[i].stop, tbl[i].bns, tbl[i].gap);
      check($sformatf("v%0d data", i), data_b, tbl[i].e_data);
      check($sformatf("v%0d valid", i), valid_b, tbl[i].e_valid);
      check($sformatf("v%0d ferr", i), b_fe - s_fe, tbl[i].e_fe);
      check($sformatf("v%0d ovr", i), b_ov - s_ov, tbl[i].e_ov);
    end

    // Stop bit low, then a break: busy held until release.
    @(posedge clk); #1;
    rdy_b = 1'b1;
    s_fe = b_fe; s_v = b_v;
    send(1'b1, 8'h55, 1'b0, 80.0, 0);
    repeat (40) @(posedge clk);
    #1;
    check("brk busy", busy_b, 1);
    check("brk ferr", b_fe - s_fe, 1);
    check("brk data", data_b, 8'h81);
    rx_b = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("brk busy end", busy_b, 0);
    check("brk valid", b_v - s_v, 0);
    repeat (20) @(posedge clk);

    // Accept and new load in the same cycle: load wins.
    @(posedge clk); #1;
    rdy_b = 1'b0;
    send(1'b1, 8'h11, 1'b1, 80.0, 2);
    check("lw first valid", valid_b, 1);
    @(posedge clk); #1;
    s_ov = b_ov;
    fork
      send(1'b1, 8'h22, 1'b1, 80.0, 2);
    join_none
    repeat (78) @(posedge clk);
    #1;
    rdy_b = 1'b1;
    @(posedge clk); #1;
    check("lw valid", valid_b, 1);
    check("lw data", data_b, 8'h22);
    @(posedge clk); #1;
    check("lw valid clr", valid_b, 0);
    wait fork;
    check("lw ovr", b_ov - s_ov, 0);

    // Reset mid-DATA with the line low.
    @(posedge clk); #1;
    rdy_b = 1'b0;
    send(1'b1, 8'h5A, 1'b1, 80.0, 2);
    @(posedge clk); #1;
    fork
      send(1'b1, 8'h00, 1'b1, 80.0, 2);
      begin
        repeat (30) @(posedge clk);
        #1;
        rst_b = 1'b0;
        #1;
        check("mid rst data", data_b, 0);
        check("mid rst valid", valid_b, 0);
        check("mid rst busy", busy_b, 0);
        check("mid rst ferr", fe_b, 0);
        check("mid rst ovr", ov_b, 0);
        #12;
        rst_b = 1'b1;
        s_bz = b_bz; s_v = b_v; s_fe = b_fe;
      end
    join
    check("post rst busy", b_bz - s_bz, 0);
    check("post rst valid", b_v - s_v, 0);
    check("post rst ferr", b_fe - s_fe, 0);
    @(posedge clk); #1;
    rdy_b = 1'b1;
    s_v = b_v;
    send(1'b1, 8'h81, 1'b1, 80.0, 2);
    check("post rst data", data_b, 8'h81);
    check("post rst vcnt", b_v - s_v, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_8n1.md
# uart_rx_8n1

UART receiver for 8N1 serial frames, clocked from the 12 MHz internal oscillator domain. It sits directly behind the `uartrx` pad and in front of the consumers that currently take the raw line, such as the RGB indicator logic or a TX loopback path. It synchronises the asynchronous line, validates the start bit, samples eight data bits LSB-first at mid-bit, and checks the stop bit. Each good byte is presented with a valid/ready handshake, and the block flags framing errors and overruns.

## Interface
- `CLKS_PER_BIT`, 1250: `clk` cycles per bit (12 MHz / 9600 baud). Legal range 8..65535.
- `clk` input 1: system clock, the 12 MHz oscillator output; all logic is on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset; deassertion is synchronised externally.
- `rx` input 1: serial line, asynchronous to `clk`; idles high.
- `rx_data` output 8: last good byte; reset 0x00.
- `rx_valid` output 1: level, high while `rx_data` holds an unread byte; reset 0.
- `rx_ready` input 1: consumer accepts `rx_data` in any cycle where `rx_valid && rx_ready`.
- `rx_busy` output 1: high in any state other than IDLE; reset 0.
- `frame_err` output 1: one-cycle pulse when the stop bit is sampled low; reset 0.
- `overrun` output 1: one-cycle pulse when a good byte completes while `rx_valid` is still high; reset 0.

## Operation
- Input path: 2-FF synchroniser on `rx` produces `rx_s`. A one-cycle-delayed copy, `rx_q`, is used for edge detection. Reset loads both synchroniser flops and `rx_q` with 0, so a line held low at reset release is never taken as a start bit.
- Bit-timing constants: H = CLKS_PER_BIT/2 (integer division). The bit counter is 16 bits and reloads on every state entry.
- State machine states are IDLE, START, DATA, STOP and WAIT_IDLE.
  - IDLE → START on a falling edge (`rx_q`=1, `rx_s`=0).
  - START: wait H cycles, then sample. If `rx_s`=0 → DATA; if `rx_s`=1 it is a glitch → IDLE with no output activity.
  - DATA: sample every CLKS_PER_BIT cycles into a shift register, LSB first; after bit 7 → STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - If `rx_s`=1: load `rx_data` and set `rx_valid`. If `rx_valid` was already high and not being accepted that cycle, pulse `overrun`; the new byte overwrites the old one. Then → IDLE.
    - If `rx_s`=0: pulse `frame_err`; `rx_data` and `rx_valid` are unchanged. Then → WAIT_IDLE.
  - WAIT_IDLE → IDLE once `rx_s`=1. This prevents a break condition (line held low) from retriggering reception.
- Handshake: `rx_valid` clears the cycle after `rx_valid && rx_ready`. If an accept and a new-byte load fall in the same cycle, the load wins: `rx_valid` stays 1, the new data is taken, and no overrun is flagged.
- Reset mid-frame: all state returns to IDLE and all outputs go to their reset values immediately, because the reset is asynchronous. The partially received byte is discarded.

## Timing
- Let t0 be the first cycle with `rx_s`=0 in IDLE; t0 is 2–3 cycles after the `rx` pad edge.
- The start check samples at t0+H.
- Data bit i (0..7) is sampled at t0+H+(i+1)·CLKS_PER_BIT.
- The stop bit is sampled at t0+H+9·CLKS_PER_BIT.
- `rx_valid`, `frame_err` and `overrun` are registered and change at t0+H+9·CLKS_PER_BIT+1. These positions are exact; no ±1 slack is allowed.
- A back-to-back frame is accepted: a start edge arriving in the first IDLE cycle after STOP is detected.
- Baud tolerance: ±2% cumulative drift must still sample every bit inside its centre half.

## Structure
- Shared package `uart_pkg`, also used by `uart_tx_8n1`, holds:
  - the `uart_rx_state_t` enum (IDLE, START, DATA, STOP, WAIT_IDLE);
  - the constant `UART_CLKS_9600_12M` = 1250.
- Sub-module `sync_2ff`: a generic 2-flop synchroniser with a reset-value parameter, instantiated here with reset value 0.
- Expected size is about 150 RTL lines.

## Test plan
- Byte 0x46 ('F') at 9600 baud, `rx_ready`=1 → `rx_data`=0x46; `rx_valid` high for exactly 1 cycle at t0+H+9·1250+1; no `frame_err` or `overrun`.
- Low glitch of 400 cycles on an idle line → no `rx_valid`; `rx_busy` drops after H cycles; FSM is back in IDLE.
- Frame 0x55 with stop bit 0 → `frame_err` pulses once; `rx_data` keeps its previous value; `rx_busy` stays high until the line returns high.
- Frames 0xA5 then 0x3C sent back-to-back with `rx_ready`=0 → first sets `rx_valid`; second pulses `overrun`, leaves `rx_data`=0x3C and keeps `rx_valid`=1.
- `rst_n` pulsed low mid-DATA while the line is low, released while the line is still low → all outputs 0 immediately; no reception until a fresh high→low edge; the next full 0x81 frame is received correctly.
- Run with CLKS_PER_BIT=8 and a transmitter 2% fast or slow on 0xFF and 0x00 frames → all bytes are received correctly.
